// File: rtl/change_dispenser.sv
// Change payout controller: greedy coin selection over four hoppers, one solenoid pulse per coin.
// Define CHANGE_AUDIT_EN to build the audit_total accumulator of value paid out.
module change_dispenser #(
  parameter int          PULSE_CYCLES = 4,
  parameter int          GAP_CYCLES   = 2,
  parameter logic [10:0] DENOM0       = 11'd10,
  parameter logic [10:0] DENOM1       = 11'd5,
  parameter logic [10:0] DENOM2       = 11'd2,
  parameter logic [10:0] DENOM3       = 11'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        change_valid,
  input  logic [10:0] change_amount,
  output logic        change_ready,
  input  logic        refill_en,
  input  logic [1:0]  refill_sel,
  input  logic [3:0]  refill_qty,
  output logic        coin_eject,
  output logic [1:0]  coin_sel,
  output logic        done,
  output logic [10:0] shortfall,
  output logic        redlight,
  output logic [31:0] hopper_count,
  output logic [15:0] audit_total
);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, FINISH} state_t;

  state_t      state;
  logic [10:0] remaining;
  logic [7:0]  timer;
  logic [7:0]  count      [4];
  logic [7:0]  count_next [4];
  logic        pick_found;
  logic [1:0]  pick_idx;
  logic        eject_done;

  function automatic logic [10:0] denom_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return DENOM0;
      2'd1:    return DENOM1;
      2'd2:    return DENOM2;
      default: return DENOM3;
    endcase
  endfunction

  assign eject_done = (state == EJECT) && (timer == 8'(PULSE_CYCLES - 1));

  // Scanning from the smallest coin upward leaves the largest usable hopper as the pick.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if ((denom_of(2'(i)) <= remaining) && (count[i] != 8'd0)) begin
        pick_found = 1'b1;
        pick_idx   = 2'(i);
      end
    end
  end

  // Refill and eject may hit the same hopper together; the sum saturates only after both apply.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      logic [9:0] sum;
      sum = {2'b00, count[i]};
      if (refill_en && (refill_sel == 2'(i)))
        sum = sum + {6'd0, refill_qty};
      if (eject_done && (coin_sel == 2'(i)))
        sum = sum - 10'd1;
      count_next[i] = (sum > 10'd255) ? 8'd255 : sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) count[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) count[i] <= count_next[i];
    end
  end

  assign hopper_count = {count[3], count[2], count[1], count[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      change_ready <= 1'b1;
      coin_eject   <= 1'b0;
      coin_sel     <= 2'd0;
      done         <= 1'b0;
      shortfall    <= 11'd0;
      redlight     <= 1'b0;
      remaining    <= 11'd0;
      timer        <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (change_valid) begin
            remaining    <= change_amount;
            redlight     <= 1'b0;
            shortfall    <= 11'd0;
            change_ready <= 1'b0;
            if (change_amount == 11'd0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= SELECT;
            end
          end
        end
        SELECT: begin
          if (pick_found) begin
            coin_sel   <= pick_idx;
            coin_eject <= 1'b1;
            timer      <= 8'd0;
            state      <= EJECT;
          end else begin
            if (remaining != 11'd0) begin
              shortfall <= remaining;
              redlight  <= 1'b1;
            end
            done  <= 1'b1;
            state <= FINISH;
          end
        end
        EJECT: begin
          if (eject_done) begin
            coin_eject <= 1'b0;
            remaining  <= remaining - denom_of(coin_sel);
            timer      <= 8'd0;
            state      <= GAP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        GAP: begin
          if (timer == 8'(GAP_CYCLES - 1)) begin
            timer <= 8'd0;
            state <= SELECT;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        FINISH: begin
          change_ready <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CHANGE_AUDIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      audit_total <= 16'd0;
    else if (eject_done)
      audit_total <= audit_total + {5'd0, denom_of(coin_sel)};
  end
`else
  assign audit_total = 16'd0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: greedy payout model, refill saturation, reset mid-eject.
module tb_change_dispenser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        change_valid = 1'b0;
  logic [10:0] change_amount = 11'd0;
  logic        change_ready;
  logic        refill_en = 1'b0;
  logic [1:0]  refill_sel = 2'd0;
  logic [3:0]  refill_qty = 4'd0;
  logic        coin_eject;
  logic [1:0]  coin_sel;
  logic        done;
  logic [10:0] shortfall;
  logic        redlight;
  logic [31:0] hopper_count;
  logic [15:0] audit_total;

  int tests_run = 0;
  int tests_failed = 0;
  int model_cnt [4];
  int model_audit;
  int denoms [4] = '{10, 5, 2, 1};

  change_dispenser dut (
    .clk(clk), .rst_n(rst_n),
    .change_valid(change_valid), .change_amount(change_amount), .change_ready(change_ready),
    .refill_en(refill_en), .refill_sel(refill_sel), .refill_qty(refill_qty),
    .coin_eject(coin_eject), .coin_sel(coin_sel), .done(done),
    .shortfall(shortfall), .redlight(redlight),
    .hopper_count(hopper_count), .audit_total(audit_total)
  );

  always #5 clk = ~clk;

  function automatic int expected_audit();
`ifdef CHANGE_AUDIT_EN
    return model_audit;
`else
    return 0;
`endif
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    change_valid = 1'b0;
    refill_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) model_cnt[i] = 0;
    model_audit = 0;
  endtask

  task automatic refill(input int sel, input int qty);
    @(negedge clk);
    refill_en = 1'b1;
    refill_sel = 2'(sel);
    refill_qty = 4'(qty);
    @(negedge clk);
    refill_en = 1'b0;
    model_cnt[sel] = (model_cnt[sel] + qty > 255) ? 255 : model_cnt[sel] + qty;
  endtask

  task automatic stock(input int c0, input int c1, input int c2, input int c3);
    int want [4];
    want = '{c0, c1, c2, c3};
    for (int h = 0; h < 4; h++) begin
      int left;
      left = want[h];
      while (left > 0) begin
        refill(h, (left > 15) ? 15 : left);
        left -= (left > 15) ? 15 : left;
      end
    end
  endtask

  task automatic check_counts(input string name);
    for (int h = 0; h < 4; h++) begin
      tests_run++;
      if (hopper_count[8*h +: 8] !== 8'(model_cnt[h])) begin
        tests_failed++;
        $display("[TB] FAIL %s count[%0d]: got %0d expected %0d", name, h, hopper_count[8*h +: 8], model_cnt[h]);
      end
    end
  endtask

  task automatic run_request(input int amount_in, input string name);
    int exp_seq[$];
    int obs_seq[$];
    int rem, exp_lat, cyc, run;
    bit got, prev, ready_bad, width_bad, seq_bad;
    rem = amount_in;
    for (int h = 0; h < 4; h++) begin
      while (rem >= denoms[h] && model_cnt[h] > 0) begin
        exp_seq.push_back(h);
        rem -= denoms[h];
        model_cnt[h]--;
        model_audit = (model_audit + denoms[h]) % 65536;
      end
    end
    exp_lat = (amount_in == 0) ? 1 : 7 * exp_seq.size() + 2;

    @(negedge clk);
    tests_run++;
    if (change_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s ready_before: got %b expected 1", name, change_ready);
    end
    change_valid = 1'b1;
    change_amount = 11'(amount_in);
    @(posedge clk);
    #1;
    change_valid = 1'b0;
    change_amount = 11'($urandom_range(0, 2047));

    got = 0; prev = 0; run = 0; cyc = 0;
    ready_bad = 0; width_bad = 0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      cyc = c;
      if (change_ready !== 1'b0) ready_bad = 1;
      if (coin_eject === 1'b1) begin
        if (!prev) obs_seq.push_back(int'(coin_sel));
        run++;
      end else if (prev) begin
        if (run != 4) width_bad = 1;
        run = 0;
      end
      prev = (coin_eject === 1'b1);
      if (done === 1'b1) begin
        got = 1;
        break;
      end
    end

    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("[TB] FAIL %s timeout: no done after %0d cycles, expected %0d", name, cyc, exp_lat);
      return;
    end
    tests_run++;
    if (cyc != exp_lat) begin
      tests_failed++;
      $display("[TB] FAIL %s latency: got %0d expected %0d", name, cyc, exp_lat);
    end
    tests_run++;
    if (ready_bad || width_bad) begin
      tests_failed++;
      $display("[TB] FAIL %s handshake/pulse: ready_low_broken=%0d pulse_width_wrong=%0d expected 0/0", name, ready_bad, width_bad);
    end
    seq_bad = (obs_seq.size() != exp_seq.size());
    if (!seq_bad)
      foreach (exp_seq[i]) if (obs_seq[i] != exp_seq[i]) seq_bad = 1;
    tests_run++;
    if (seq_bad) begin
      tests_failed++;
      $display("[TB] FAIL %s coin_seq: got %p expected %p", name, obs_seq, exp_seq);
    end
    tests_run++;
    if (shortfall !== 11'(rem) || redlight !== (rem != 0)) begin
      tests_failed++;
      $display("[TB] FAIL %s shortfall/redlight: got %0d/%b expected %0d/%b", name, shortfall, redlight, rem, rem != 0);
    end
    @(negedge clk);
    tests_run++;
    if (change_ready !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s after_done: ready=%b done=%b expected 1/0", name, change_ready, done);
    end
    check_counts(name);
    tests_run++;
    if (audit_total !== 16'(expected_audit())) begin
      tests_failed++;
      $display("[TB] FAIL %s audit: got %0d expected %0d", name, audit_total, expected_audit());
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (change_ready !== 1'b1 || coin_eject !== 1'b0 || coin_sel !== 2'd0 || done !== 1'b0 ||
        shortfall !== 11'd0 || redlight !== 1'b0 || hopper_count !== 32'd0 || audit_total !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: ready=%b eject=%b sel=%0d done=%b short=%0d red=%b counts=%h audit=%0d expected 1/0/0/0/0/0/0/0",
               change_ready, coin_eject, coin_sel, done, shortfall, redlight, hopper_count, audit_total);
    end
  endtask

  task automatic test_greedy();
    do_reset();
    stock(2, 2, 2, 2);
    run_request(18, "greedy18");
    tests_run++;
    if (hopper_count !== 32'h01010101) begin
      tests_failed++;
      $display("[TB] FAIL greedy18_counts: got %h expected 01010101", hopper_count);
    end
  endtask

  task automatic test_shortfall();
    do_reset();
    stock(0, 0, 3, 0);
    run_request(7, "short7");
    tests_run++;
    if (shortfall !== 11'd1 || redlight !== 1'b1 || hopper_count !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL short7_fixed: short=%0d red=%b counts=%h expected 1/1/0", shortfall, redlight, hopper_count);
    end
    run_request(0, "zero_after_short");
  endtask

  task automatic test_zero();
    do_reset();
    stock(1, 1, 1, 1);
    run_request(0, "zero");
    run_request(0, "zero_back_to_back");
  endtask

  task automatic test_refill_saturation();
    do_reset();
    stock(0, 0, 0, 250);
    check_counts("refill250");
    refill(3, 15);
    tests_run++;
    if (hopper_count[31:24] !== 8'd255) begin
      tests_failed++;
      $display("[TB] FAIL refill_sat: got %0d expected 255", hopper_count[31:24]);
    end
  endtask

  task automatic test_refill_collision();
    bit got;
    do_reset();
    stock(0, 0, 0, 5);
    @(negedge clk);
    change_valid = 1'b1;
    change_amount = 11'd1;
    @(posedge clk);
    #1;
    change_valid = 1'b0;
    got = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 5) begin
        tests_run++;
        if (coin_eject !== 1'b1 || coin_sel !== 2'd3) begin
          tests_failed++;
          $display("[TB] FAIL collision_eject: eject=%b sel=%0d expected 1/3", coin_eject, coin_sel);
        end
        refill_en = 1'b1;
        refill_sel = 2'd3;
        refill_qty = 4'd3;
      end else begin
        refill_en = 1'b0;
      end
      if (done === 1'b1) begin
        got = 1;
        break;
      end
    end
    refill_en = 1'b0;
    model_cnt[3] = 7;
    model_audit += 1;
    tests_run++;
    if (!got || hopper_count[31:24] !== 8'd7) begin
      tests_failed++;
      $display("[TB] FAIL collision_count: done_seen=%0d count=%0d expected 1/7", got, hopper_count[31:24]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_eject();
    do_reset();
    stock(10, 0, 0, 0);
    @(negedge clk);
    change_valid = 1'b1;
    change_amount = 11'd100;
    @(posedge clk);
    #1;
    change_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (coin_eject !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_pre: eject=%b expected 1", coin_eject);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (coin_eject !== 1'b0 || change_ready !== 1'b1 || done !== 1'b0 || shortfall !== 11'd0 ||
        redlight !== 1'b0 || hopper_count !== 32'd0 || audit_total !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_async: eject=%b ready=%b done=%b short=%0d red=%b counts=%h audit=%0d expected 0/1/0/0/0/0/0",
               coin_eject, change_ready, done, shortfall, redlight, hopper_count, audit_total);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) model_cnt[i] = 0;
    model_audit = 0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (change_ready !== 1'b1 || coin_eject !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_release: ready=%b eject=%b expected 1/0", change_ready, coin_eject);
    end
  endtask

  task automatic test_random();
    do_reset();
    stock($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 2) == 0)
        refill($urandom_range(0, 3), $urandom_range(0, 15));
      run_request($urandom_range(0, 60), $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_audit();
    do_reset();
    stock(2, 2, 2, 2);
    run_request(18, "audit18");
    run_request(7, "audit7");
    tests_run++;
`ifdef CHANGE_AUDIT_EN
    if (audit_total !== 16'd25) begin
      tests_failed++;
      $display("[TB] FAIL audit_total: got %0d expected 25", audit_total);
    end
`else
    if (audit_total !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL audit_total: got %0d expected 0", audit_total);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_greedy();
    test_shortfall();
    test_zero();
    test_refill_saturation();
    test_refill_collision();
    test_reset_mid_eject();
    test_random();
    test_audit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
